// File: rtl/voter_pkg.sv
// Shared types and helpers for the k-of-N threshold voter and its persistence filter.
package voter_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } voter_state_t;

  // Widest channel vector the popcount helper accepts; callers zero-extend into it.
  localparam int unsigned MaxN = 256;
  localparam int unsigned PopW = $clog2(MaxN + 1);

  // Width needed to hold a count of 0..n.
  function automatic int unsigned cw_of(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [PopW-1:0] popcount(input logic [MaxN-1:0] v);
    logic [PopW-1:0] s;
    s = '0;
    for (int i = 0; i < MaxN; i++) begin
      s = s + PopW'(v[i]);
    end
    return s;
  endfunction

endpackage

// File: rtl/persist_filter.sv
// Persistence filter: q follows d only after HOLD consecutive valid disagreeing samples.
module persist_filter
  import voter_pkg::*;
#(
  parameter int unsigned HOLD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic v,
  input  logic d,
  output logic q,
  output logic changed
);

  localparam int unsigned RW = $clog2(HOLD + 1);

  voter_state_t  r_state, w_state_d;
  logic [RW-1:0] r_run, w_run_d;
  logic          r_q, w_q_d;
  logic          r_changed, w_changed_d;

  always_comb begin
    w_state_d   = r_state;
    w_run_d     = r_run;
    w_q_d       = r_q;
    w_changed_d = 1'b0;
    // Invalid cycles leave state and run untouched.
    if (v) begin
      unique case (r_state)
        STABLE: begin
          if (d == r_q) begin
            w_run_d = '0;
          end else if (HOLD == 1) begin
            w_q_d       = d;
            w_changed_d = 1'b1;
          end else begin
            w_run_d   = RW'(1);
            w_state_d = PENDING;
          end
        end
        PENDING: begin
          if (d == r_q) begin
            w_run_d   = '0;
            w_state_d = STABLE;
          end else if (r_run == RW'(HOLD - 1)) begin
            w_q_d       = d;
            w_changed_d = 1'b1;
            w_run_d     = '0;
            w_state_d   = STABLE;
          end else begin
            w_run_d = r_run + RW'(1);
          end
        end
        default: begin
          w_state_d = STABLE;
          w_run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= STABLE;
      r_run     <= '0;
      r_q       <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_run     <= w_run_d;
      r_q       <= w_q_d;
      r_changed <= w_changed_d;
    end
  end

  assign q       = r_q;
  assign changed = r_changed;

endmodule

// File: rtl/threshold_voter_seq.sv
// Registered k-of-N threshold voter with persistence filter (2-cycle latency).
// Optional per-channel disagreement output enabled by VOTER_MISMATCH_EN.
module threshold_voter_seq
  import voter_pkg::*;
#(
  parameter  int unsigned N    = 4,
  parameter  int unsigned HOLD = 2,
  localparam int unsigned CW   = cw_of(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [N-1:0]  x,
  input  logic [CW-1:0] thr,
  output logic [CW-1:0] count,
  output logic          raw,
  output logic          out_valid,
  output logic          f,
  output logic          changed
`ifdef VOTER_MISMATCH_EN
  ,
  output logic [N-1:0]  mismatch
`endif
);

  logic [CW-1:0] w_pop;
  logic [CW-1:0] r_count;
  logic          r_raw;
  logic          r_v1;
  logic          r_out_valid;

  assign w_pop = CW'(popcount(MaxN'(x)));

  // Stage 1: count and raw hold their last valid values across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_raw       <= 1'b0;
      r_v1        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_v1        <= in_valid;
      r_out_valid <= r_v1;
      if (in_valid) begin
        r_count <= w_pop;
        r_raw   <= (w_pop >= thr);
      end
    end
  end

  persist_filter #(
    .HOLD(HOLD)
  ) u_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .v      (r_v1),
    .d      (r_raw),
    .q      (f),
    .changed(changed)
  );

`ifdef VOTER_MISMATCH_EN
  logic [N-1:0] r_x_q;
  logic [N-1:0] r_x2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_q <= '0;
      r_x2  <= '0;
    end else begin
      if (in_valid) begin
        r_x_q <= x;
      end
      if (r_v1) begin
        r_x2 <= r_x_q;
      end
    end
  end

  // f only moves on valid samples, so this holds between them just like r_x2.
  assign mismatch = r_x2 ^ {N{f}};
`endif

  assign count     = r_count;
  assign raw       = r_raw;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_threshold_voter_seq.sv
// Bench for threshold_voter_seq: HOLD=2 and HOLD=1 instances share stimulus; scoreboard queues.
module tb_threshold_voter_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] x = 4'd0;
  logic [2:0] thr = 3'd0;

  logic [2:0] count, count1;
  logic       raw, raw1, out_valid, out_valid1, f, f1, changed, changed1;
`ifdef VOTER_MISMATCH_EN
  logic [3:0] mismatch, mismatch1;
`endif

  threshold_voter_seq #(.N(4), .HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .thr(thr),
    .count(count), .raw(raw), .out_valid(out_valid), .f(f), .changed(changed)
`ifdef VOTER_MISMATCH_EN
    , .mismatch(mismatch)
`endif
  );

  threshold_voter_seq #(.N(4), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .thr(thr),
    .count(count1), .raw(raw1), .out_valid(out_valid1), .f(f1), .changed(changed1)
`ifdef VOTER_MISMATCH_EN
    , .mismatch(mismatch1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] count;
    logic       raw;
  } s1_t;

  typedef struct packed {
    logic       f;
    logic       chg;
    logic [3:0] mm;
  } s2_t;

  typedef struct {
    logic [3:0] x;
    logic [2:0] thr;
    logic [2:0] ecount;
    logic       eraw;
  } vec_t;

  s1_t s1_q[$];
  s2_t s2_q[$];
  s2_t s2h_q[$];

  int checks = 0;
  int failures = 0;
  int ov_cnt = 0;
  int chg_cnt = 0;

  // Reference filter state: f and count of consecutive disagreeing valid samples.
  bit m2_f, m1_f;
  int m2_dis, m1_dis;

  logic tb_v1, tb_v2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_v1 <= 1'b0;
      tb_v2 <= 1'b0;
    end else begin
      tb_v1 <= in_valid;
      tb_v2 <= tb_v1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pop4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic filt(input bit d, input int hold, inout bit fm, inout int dis, output bit chg);
    chg = 1'b0;
    if (d != fm) dis = dis + 1;
    else dis = 0;
    if (dis == hold) begin
      fm  = d;
      chg = 1'b1;
      dis = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_raw"}, 32'(raw), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_f"}, 32'(f), 0);
    chk({tag, "_changed"}, 32'(changed), 0);
    chk({tag, "_f_h1"}, 32'(f1), 0);
    chk({tag, "_out_valid_h1"}, 32'(out_valid1), 0);
`ifdef VOTER_MISMATCH_EN
    chk({tag, "_mismatch"}, 32'(mismatch), 0);
`endif
  endtask

  // Called at a falling edge; drives one cycle of stimulus and returns at the next falling edge.
  task automatic drive(input bit v, input logic [3:0] xv, input logic [2:0] tv,
                       input bit tab, input logic [2:0] ec, input bit er);
    s1_t e1;
    s2_t e2;
    bit  chg, r;
    in_valid = v;
    x        = xv;
    thr      = tv;
    if (v) begin
      if (tab) begin
        e1.count = ec;
        r        = er;
      end else begin
        e1.count = 3'(pop4(xv));
        r        = (pop4(xv) >= int'(tv));
      end
      e1.raw = r;
      s1_q.push_back(e1);
      filt(r, 2, m2_f, m2_dis, chg);
      e2.f = m2_f; e2.chg = chg; e2.mm = xv ^ {4{m2_f}};
      s2_q.push_back(e2);
      filt(r, 1, m1_f, m1_dis, chg);
      e2.f = m1_f; e2.chg = chg; e2.mm = xv ^ {4{m1_f}};
      s2h_q.push_back(e2);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset(input int phase);
    @(posedge clk);
    #(phase);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_zero("async_reset");
    s1_q.delete();
    s2_q.delete();
    s2h_q.delete();
    m2_f = 0; m2_dis = 0; m1_f = 0; m1_dis = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    s1_t e1;
    s2_t e2;
    if (rst_n) begin
      chk("out_valid_timing", 32'(out_valid), 32'(tb_v2));
      chk("out_valid_timing_h1", 32'(out_valid1), 32'(tb_v2));
      chk("changed_gated", 32'(changed & ~out_valid), 0);
      if (tb_v1) begin
        if (s1_q.size() == 0) begin
          chk("s1_queue_underflow", 1, 0);
        end else begin
          e1 = s1_q.pop_front();
          chk("count", 32'(count), 32'(e1.count));
          chk("raw", 32'(raw), 32'(e1.raw));
          chk("count_h1", 32'(count1), 32'(e1.count));
          chk("raw_h1", 32'(raw1), 32'(e1.raw));
        end
      end
      if (out_valid) begin
        ov_cnt++;
        if (s2_q.size() == 0) begin
          chk("s2_queue_underflow", 1, 0);
        end else begin
          e2 = s2_q.pop_front();
          chk("f", 32'(f), 32'(e2.f));
          chk("changed", 32'(changed), 32'(e2.chg));
`ifdef VOTER_MISMATCH_EN
          chk("mismatch", 32'(mismatch), 32'(e2.mm));
`endif
        end
      end
      if (changed) chg_cnt++;
      if (out_valid1) begin
        if (s2h_q.size() == 0) begin
          chk("s2h_queue_underflow", 1, 0);
        end else begin
          e2 = s2h_q.pop_front();
          chk("f_h1", 32'(f1), 32'(e2.f));
          chk("changed_h1", 32'(changed1), 32'(e2.chg));
`ifdef VOTER_MISMATCH_EN
          chk("mismatch_h1", 32'(mismatch1), 32'(e2.mm));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[11];
    int   snap_chg, snap_ov;

    tab[0]  = '{x: 4'b0011, thr: 3'd0, ecount: 3'd2, eraw: 1'b1};
    tab[1]  = '{x: 4'b0011, thr: 3'd1, ecount: 3'd2, eraw: 1'b1};
    tab[2]  = '{x: 4'b0011, thr: 3'd2, ecount: 3'd2, eraw: 1'b1};
    tab[3]  = '{x: 4'b0011, thr: 3'd3, ecount: 3'd2, eraw: 1'b0};
    tab[4]  = '{x: 4'b0011, thr: 3'd5, ecount: 3'd2, eraw: 1'b0};
    tab[5]  = '{x: 4'b1111, thr: 3'd4, ecount: 3'd4, eraw: 1'b1};
    tab[6]  = '{x: 4'b1110, thr: 3'd4, ecount: 3'd3, eraw: 1'b0};
    tab[7]  = '{x: 4'b0000, thr: 3'd1, ecount: 3'd0, eraw: 1'b0};
    tab[8]  = '{x: 4'b1000, thr: 3'd1, ecount: 3'd1, eraw: 1'b1};
    tab[9]  = '{x: 4'b0000, thr: 3'd0, ecount: 3'd0, eraw: 1'b1};
    tab[10] = '{x: 4'b1111, thr: 3'd7, ecount: 3'd4, eraw: 1'b0};

    m2_f = 0; m2_dis = 0; m1_f = 0; m1_dis = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // First sample after reset: raw=1 at t+1, f still 0 at t+2 (pending).
    drive(1'b1, 4'b1111, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(2);
    chk("first_sample_f_pending", 32'(f), 0);

    // Two agreeing samples flip f with a single changed pulse.
    do_reset(2);
    snap_chg = chg_cnt;
    drive(1'b1, 4'b0111, 3'd3, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 4'b0111, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(3);
    chk("rise_f", 32'(f), 1);
    chk("rise_changed_pulses", 32'(chg_cnt - snap_chg), 1);

    // One-sample glitch is rejected.
    snap_chg = chg_cnt;
    drive(1'b1, 4'b0001, 3'd3, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 4'b1110, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(3);
    chk("glitch_f", 32'(f), 1);
    chk("glitch_changed_pulses", 32'(chg_cnt - snap_chg), 0);
    // A fresh single glitch must again be rejected (run was cleared).
    drive(1'b1, 4'b0001, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(1);
    drive(1'b1, 4'b1111, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(3);
    chk("glitch2_f", 32'(f), 1);

    // Gapped disagreement: idle cycles neither advance nor clear the run.
    snap_ov = ov_cnt;
    drive(1'b1, 4'b0000, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(3);
    chk("gap_f_mid", 32'(f), 1);
    drive(1'b1, 4'b0000, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(3);
    chk("gap_f", 32'(f), 0);
    chk("gap_out_valid_pulses", 32'(ov_cnt - snap_ov), 2);

    // Mid-stream async reset drops in-flight work and clears f.
    drive(1'b1, 4'b0111, 3'd3, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 4'b0111, 3'd3, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 4'b1111, 3'd0, 1'b0, 3'd0, 1'b0);
    chk("pre_reset_f", 32'(f), 1);
    do_reset(4);
    snap_ov = ov_cnt;
    idle(3);
    chk("post_reset_no_out_valid", 32'(ov_cnt - snap_ov), 0);

    // Threshold boundary table, back to back.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tab[i].x, tab[i].thr, 1'b1, tab[i].ecount, tab[i].eraw);
    end
    idle(3);
    chk("sweep_h1_f_tracks_last_raw", 32'(f1), 0);

`ifdef VOTER_MISMATCH_EN
    do_reset(1);
    drive(1'b1, 4'b1011, 3'd3, 1'b0, 3'd0, 1'b0);
    drive(1'b1, 4'b1011, 3'd3, 1'b0, 3'd0, 1'b0);
    idle(3);
    chk("mismatch_f", 32'(f), 1);
    chk("mismatch_value", 32'(mismatch), 32'h4);
`endif

    // Random stream with gaps.
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 5)),
            1'b0, 3'd0, 1'b0);
    end
    idle(4);

    chk("s1_drained", 32'(s1_q.size()), 0);
    chk("s2_drained", 32'(s2_q.size()), 0);
    chk("s2h_drained", 32'(s2h_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/threshold_voter_seq.md
Name: threshold_voter_seq

Overview:
Parametrised, registered successor to the team's 4-input "at least 3 of 4" combinational voter.
- Counts asserted bits across N channels and compares the count against a runtime threshold.
- Passes the raw vote through a persistence filter, so the output flips only after HOLD consecutive valid disagreeing samples.
- Used as a glitch-tolerant k-of-N decision stage between sampled sensor or logic channels and downstream control.

Parameters:
- N, default 4: number of input channels; N ≥ 2.
- HOLD, default 2: consecutive valid disagreeing samples required before f flips; HOLD ≥ 1.
- CW, default $clog2(N+1): derived localparam, width of the count and threshold fields.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: x and thr are sampled this cycle.
- x, input, N: channel bits.
- thr, input, CW: threshold k; sampled together with x.
- count, output, CW: registered popcount of the last valid x.
- raw, output, 1: registered unfiltered vote, (count ≥ thr).
- out_valid, output, 1: one-cycle pulse; f and changed reflect a new sample.
- f, output, 1: filtered vote.
- changed, output, 1: one-cycle pulse when f toggles.

Behaviour:
- Reset (async assert, sync-released by the user): count=0, raw=0, out_valid=0, f=0, changed=0, run counter=0, state=STABLE. Reset mid-run drops the in-flight stage-1 sample and clears the filter run.
- Stage 1, registered on cycle t+1 after an in_valid at cycle t:
  - count ← popcount(x).
  - raw ← (popcount(x) ≥ thr), unsigned compare.
  - v1 ← in_valid.
  - If in_valid=0, count and raw hold their values and v1=0.
- Threshold boundaries:
  - thr=0 gives raw=1 always.
  - thr>N gives raw=0 always.
  - thr=N gives an AND vote.
  - thr=1 gives an OR vote.
- Stage 2 is the filter FSM; it acts only when v1=1. Its results are registered at t+2, so total latency from in_valid to out_valid/f is 2 cycles. out_valid = v1 delayed one cycle.
- FSM state STABLE:
  - raw==f: stay in STABLE; run=0.
  - raw≠f and HOLD==1: f←raw, changed=1, stay in STABLE.
  - raw≠f and HOLD>1: run=1, go to PENDING.
- FSM state PENDING:
  - raw==f: run=0, go to STABLE. The spurious excursion is rejected.
  - raw≠f and run+1==HOLD: f←raw, changed=1, run=0, go to STABLE.
  - raw≠f otherwise: run←run+1.
- Cycles with v1=0 freeze the FSM state and run; invalid gaps neither advance nor clear the run.
- changed and out_valid are single-cycle pulses and are never asserted when v1 was 0.
- The run counter is $clog2(HOLD+1) bits wide and never exceeds HOLD-1.
- Back-to-back in_valid every cycle is supported at full throughput; there is no backpressure.

Optional Feature:
- Macro: VOTER_MISMATCH_EN.
- Defined:
  - Adds output mismatch[N-1:0], registered at stage 2 alongside f.
  - mismatch = x_q ^ {N{f_next}}, where x_q is x captured in stage 1 and f_next is the f value written this cycle. It flags the channels disagreeing with the voted result.
  - Reset value is 0. mismatch holds between valid samples.
- Undefined: the port and the x_q register are absent; all other behaviour is identical.

Decomposition:
- Package voter_pkg holds:
  - typedef enum logic {STABLE, PENDING} voter_state_t;
  - function popcount(N-bit) returning CW bits;
  - localparam helper for CW.
- One sub-module, persist_filter: the stage-2 FSM plus run counter.
  - Parameter: HOLD.
  - Ports: clk, rst_n, v, d, q, changed.
  - Reusable by other debounce-style blocks.

Test Plan (N=4, HOLD=2 unless noted):
- Reset with rst_n=0 mid-stream at arbitrary phase → all outputs 0 asynchronously; after release, first valid x=4'b1111, thr=3 gives raw=1 at t+1 and f still 0 at t+2 (PENDING).
- Valid x=4'b0111 twice consecutively, thr=3 → count=3, raw=1; f rises at t+3 of the first sample with changed=1 for one cycle.
- Glitch: f=1, then valid x=4'b0001 once, then x=4'b1110 → f stays 1, changed never pulses, FSM returns to STABLE.
- Gapped sequence: disagreeing valid, 3 idle cycles, disagreeing valid → f flips after the second valid; out_valid pulses exactly twice.
- Threshold sweep with x=4'b0011 and thr=0,1,2,3,5 → raw = 1,1,1,0,0. With HOLD=1, f tracks raw with 2-cycle latency.
- With VOTER_MISMATCH_EN defined: f=1 and x=4'b1011 → mismatch=4'b0100.
